// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, overlap control and a
// saturating match counter. The match pulse w and all status outputs are registered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FILL  | fewer than PAT_W qualified bits collected since restart
// ST_ARMED | history full; every qualified bit can complete a match
module seq_detect_param #(
   parameter int unsigned      PAT_W       = 5,
   parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(5'b01110),
   parameter int unsigned      CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             a,
   input  logic             load,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   input  logic             cnt_clr,
   output logic             w,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int unsigned      FW        = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {ST_FILL = 1'b0, ST_ARMED = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   hist_q, hist_d, hist_n;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [FW-1:0]      fill_q, fill_d, fill_n;
   logic               w_q, w_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sat_q, sat_d;
   logic               hit;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_FILL;
         hist_q  <= '0;
         pat_q   <= DEFAULT_PAT;
         fill_q  <= '0;
         w_q     <= 1'b0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         pat_q   <= pat_d;
         fill_q  <= fill_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      pat_d   = pat_q;
      fill_d  = fill_q;
      w_d     = 1'b0;
      hit     = 1'b0;
      hist_n  = {hist_q[PAT_W-2:0], a};
      // Once armed the fill count is pinned at full, so no increment is needed.
      fill_n  = (state_q == ST_ARMED) ? FILL_FULL : fill_q + FW'(1);

      if (load) begin
         pat_d   = pattern;
         hist_d  = '0;
         fill_d  = '0;
         state_d = ST_FILL;
      end else if (en) begin
         hit    = (fill_n == FILL_FULL) && (hist_n == pat_q);
         w_d    = hit;
         hist_d = hist_n;
         if (hit && !overlap) begin
            fill_d  = '0;
            state_d = ST_FILL;
         end else begin
            fill_d  = fill_n;
            state_d = (fill_n == FILL_FULL) ? ST_ARMED : ST_FILL;
         end
      end

      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      sat_d = (cnt_d == CNT_MAX);
   end

   assign w         = w_q;
   assign match_cnt = cnt_q;
   assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (8-bit and 2-bit counters) share stimulus
// and are compared each cycle against a bit-queue reference model plus directed vectors.
module tb_seq_detect_param;

   localparam logic [4:0] DEF_PAT = 5'b01110;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       a = 1'b0;
   logic       load = 1'b0;
   logic [4:0] pattern = 5'b0;
   logic       overlap = 1'b0;
   logic       cnt_clr = 1'b0;
   logic       w8, sat8, w2, sat2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: bits collected since the last restart, newest at the back.
   bit         m_bits[$];
   logic [4:0] m_pat = DEF_PAT;
   int         m_w = 0;
   int         m_cnt8 = 0;
   int         m_cnt2 = 0;

   always #5 clk = ~clk;

   seq_detect_param #(.PAT_W(5), .DEFAULT_PAT(DEF_PAT), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .en(en), .a(a), .load(load), .pattern(pattern),
      .overlap(overlap), .cnt_clr(cnt_clr), .w(w8), .match_cnt(cnt8), .cnt_sat(sat8)
   );

   seq_detect_param #(.PAT_W(5), .DEFAULT_PAT(DEF_PAT), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .a(a), .load(load), .pattern(pattern),
      .overlap(overlap), .cnt_clr(cnt_clr), .w(w2), .match_cnt(cnt2), .cnt_sat(sat2)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, e, b, l, input logic [4:0] p,
                               input logic o, c);
      int hit;
      if (!r) begin
         m_bits.delete();
         m_pat  = DEF_PAT;
         m_w    = 0;
         m_cnt8 = 0;
         m_cnt2 = 0;
         return;
      end
      hit = 0;
      if (l) begin
         m_bits.delete();
         m_pat = p;
      end else if (e) begin
         m_bits.push_back(b);
         if (m_bits.size() > 5) void'(m_bits.pop_front());
         if (m_bits.size() == 5) begin
            hit = 1;
            for (int i = 0; i < 5; i++)
               if (m_bits[i] != m_pat[4-i]) hit = 0;
         end
         if (hit != 0 && !o) m_bits.delete();
      end
      m_w = hit;
      if (c) begin
         m_cnt8 = 0;
         m_cnt2 = 0;
      end else if (hit != 0) begin
         if (m_cnt8 < 255) m_cnt8++;
         if (m_cnt2 < 3) m_cnt2++;
      end
   endtask

   task automatic step(input logic r, e, b, l, input logic [4:0] p, input logic o, c);
      rst = r; en = e; a = b; load = l; pattern = p; overlap = o; cnt_clr = c;
      model_update(r, e, b, l, p, o, c);
      @(posedge clk);
      #1;
      chk("model_w8", int'(w8), m_w);
      chk("model_cnt8", int'(cnt8), m_cnt8);
      chk("model_sat8", int'(sat8), int'(m_cnt8 == 255));
      chk("model_w2", int'(w2), m_w);
      chk("model_cnt2", int'(cnt2), m_cnt2);
      chk("model_sat2", int'(sat2), int'(m_cnt2 == 3));
   endtask

   task automatic send(input logic [15:0] bits, input int n, input logic o);
      for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, bits[i], 1'b0, 5'b0, o, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic a;
      logic exp_w;
      int   exp_cnt;
   } vec_t;

   vec_t t1[10];

   initial begin
      logic [9:0] t1_bits;
      logic [9:0] t1_w;
      int         t1_cnt[10];
      logic [4:0] rpat;
      logic       rovl;
      int         gaps[4];
      logic [4:0] t3_bits;

      t1_bits = 10'b0111001110;
      t1_w    = 10'b0000100001;
      t1_cnt  = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 2};
      for (int i = 0; i < 10; i++) begin
         t1[i].a       = t1_bits[9-i];
         t1[i].exp_w   = t1_w[9-i];
         t1[i].exp_cnt = t1_cnt[i];
      end

      // Reset state
      do_reset();
      do_reset();
      chk("rst_w", int'(w8), 0);
      chk("rst_cnt", int'(cnt8), 0);
      chk("rst_sat", int'(sat8), 0);

      // T1: default pattern, no overlap, table-driven
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, t1[i].a, 1'b0, 5'b0, 1'b0, 1'b0);
         chk("t1_w", int'(w8), int'(t1[i].exp_w));
         chk("t1_cnt", int'(cnt8), t1[i].exp_cnt);
      end

      // T2: pattern 10101 with and without overlap
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b1, 5'b10101, 1'b1, 1'b0);
      send(16'b1010, 4, 1'b1);
      chk("t2o_pre", int'(w8), 0);
      send(16'b1, 1, 1'b1);
      chk("t2o_bit5", int'(w8), 1);
      send(16'b0, 1, 1'b1);
      chk("t2o_bit6", int'(w8), 0);
      send(16'b1, 1, 1'b1);
      chk("t2o_bit7", int'(w8), 1);
      chk("t2o_cnt", int'(cnt8), 2);
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b1, 5'b10101, 1'b0, 1'b0);
      send(16'b10101, 5, 1'b0);
      chk("t2n_bit5", int'(w8), 1);
      send(16'b01, 2, 1'b0);
      chk("t2n_bit7", int'(w8), 0);
      chk("t2n_cnt", int'(cnt8), 1);

      // T3: default pattern with en=0 gaps
      do_reset();
      gaps    = '{1, 2, 3, 1};
      t3_bits = 5'b01110;
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b1, t3_bits[4-k], 1'b0, 5'b0, 1'b0, 1'b0);
         chk("t3_bit_w", int'(w8), int'(k == 4));
         if (k < 4) begin
            for (int g = 0; g < gaps[k]; g++) begin
               step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 5'b0, 1'b0, 1'b0);
               chk("t3_gap_w", int'(w8), 0);
            end
         end
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0);
      chk("t3_after_w", int'(w8), 0);
      chk("t3_cnt", int'(cnt8), 1);

      // T4: reset mid-stream discards history
      do_reset();
      send(16'b0111, 4, 1'b0);
      do_reset();
      send(16'b0, 1, 1'b0);
      chk("t4_nomatch_w", int'(w8), 0);
      chk("t4_nomatch_cnt", int'(cnt8), 0);
      send(16'b0111, 4, 1'b0);
      chk("t4_pre_w", int'(w8), 0);
      send(16'b0, 1, 1'b0);
      chk("t4_match_w", int'(w8), 1);
      chk("t4_match_cnt", int'(cnt8), 1);

      // T5: 2-bit counter saturation and clear-beats-hit
      do_reset();
      for (int m = 0; m < 5; m++) begin
         send(16'b01110, 5, 1'b0);
         chk("t5_w2", int'(w2), 1);
      end
      chk("t5_cnt2", int'(cnt2), 3);
      chk("t5_sat2", int'(sat2), 1);
      chk("t5_cnt8", int'(cnt8), 5);
      send(16'b0111, 4, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 5'b0, 1'b0, 1'b1);
      chk("t5_clr_w2", int'(w2), 1);
      chk("t5_clr_cnt2", int'(cnt2), 0);
      chk("t5_clr_sat2", int'(sat2), 0);
      chk("t5_clr_cnt8", int'(cnt8), 0);

      // T6: load beats a completing bit
      do_reset();
      send(16'b0111, 4, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 5'b10101, 1'b0, 1'b0);
      chk("t6_load_w", int'(w8), 0);
      send(16'b01010, 5, 1'b0);
      chk("t6_partial_w", int'(w8), 0);
      send(16'b1, 1, 1'b0);
      chk("t6_new_w", int'(w8), 1);
      chk("t6_cnt", int'(cnt8), 1);

      // Randomized against the reference model
      do_reset();
      rovl = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 31) == 0) rovl = ~rovl;
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 63) == 0) begin
            case ($urandom_range(0, 3))
               0:       rpat = DEF_PAT;
               1:       rpat = 5'b10101;
               2:       rpat = 5'b11111;
               default: rpat = 5'($urandom);
            endcase
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, rpat,
                 rovl, 1'($urandom_range(0, 49) == 0));
         end else begin
            step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
                 5'($urandom), rovl, 1'($urandom_range(0, 99) == 0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
